// File: rtl/arccos_bisect.sv
// Arccos by bisection over the piecewise-linear cosine: returns the smallest angle code m in
// [0, PI_Q] whose PWL cosine f(m) is <= y. One request in flight, valid/ready on both sides.

`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 8
`endif
`ifndef FRAC_WIDTH
`define FRAC_WIDTH 4
`endif

module arccos_bisect #(
    parameter int DATA_W = `TOTAL_WIDTH,
    parameter int FRAC_W = `FRAC_WIDTH,
    parameter int PI_Q   = 50,
    parameter int ITER   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] y_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] x_out,
    output logic              clip,
    output logic              busy
);

    localparam int CntW = $clog2(ITER + 1);

    localparam logic signed [DATA_W-1:0] OneQ    = DATA_W'(1 << FRAC_W);
    localparam logic signed [DATA_W-1:0] NegOneQ = -OneQ;
    localparam logic signed [DATA_W-1:0] PiQ     = DATA_W'(PI_Q);

    // Segment breakpoints, slopes and intercepts of the PWL cosine (codes at ONE = 16).
    localparam logic signed [DATA_W-1:0] Seg1Start = DATA_W'(13);
    localparam logic signed [DATA_W-1:0] Seg2Start = DATA_W'(38);
    localparam logic signed [DATA_W-1:0] Slope0    = DATA_W'(-6);
    localparam logic signed [DATA_W-1:0] Slope1    = DATA_W'(-14);
    localparam logic signed [DATA_W-1:0] Slope2    = DATA_W'(-6);
    localparam logic signed [DATA_W-1:0] Icpt0     = DATA_W'(16);
    localparam logic signed [DATA_W-1:0] Icpt1     = DATA_W'(23);
    localparam logic signed [DATA_W-1:0] Icpt2     = DATA_W'(3);

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StDone
    } state_e;

    state_e                     state_q, state_d;
    logic signed [DATA_W-1:0]   lo_q, lo_d;
    logic signed [DATA_W-1:0]   hi_q, hi_d;
    logic signed [DATA_W-1:0]   y_q, y_d;
    logic signed [DATA_W-1:0]   x_q, x_d;
    logic                       clip_q, clip_d;
    logic [CntW-1:0]            cnt_q, cnt_d;

    logic [DATA_W:0]            sum;
    logic signed [DATA_W-1:0]   mid;
    logic signed [DATA_W-1:0]   f_mid;
    logic signed [DATA_W-1:0]   y_sgn;

    function automatic logic signed [DATA_W-1:0] pwl_cos(input logic signed [DATA_W-1:0] m);
        logic signed [DATA_W-1:0]   slope;
        logic signed [DATA_W-1:0]   icpt;
        logic signed [2*DATA_W-1:0] m_w;
        logic signed [2*DATA_W-1:0] s_w;
        logic signed [2*DATA_W-1:0] prod;
        if (m < Seg1Start) begin
            slope = Slope0;
            icpt  = Icpt0;
        end else if (m < Seg2Start) begin
            slope = Slope1;
            icpt  = Icpt1;
        end else begin
            slope = Slope2;
            icpt  = Icpt2;
        end
        m_w  = (2*DATA_W)'(m);
        s_w  = (2*DATA_W)'(slope);
        prod = m_w * s_w;
        // Arithmetic shift floors toward -inf, matching the reference cosine unit.
        return DATA_W'(prod >>> FRAC_W) + icpt;
    endfunction

    always_comb begin
        sum   = {1'b0, lo_q} + {1'b0, hi_q};
        mid   = $signed(sum[DATA_W:1]);
        f_mid = pwl_cos(mid);
        y_sgn = $signed(y_in);
    end

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        y_d       = y_q;
        x_d       = x_q;
        clip_d    = clip_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    y_d     = y_sgn;
                    lo_d    = '0;
                    hi_d    = PiQ;
                    cnt_d   = '0;
                    clip_d  = (y_sgn > OneQ) || (y_sgn < NegOneQ);
                    state_d = StSearch;
                end
            end
            StSearch: begin
                // Once the interval has collapsed, hold it so lo cannot run past PI_Q.
                if (lo_q < hi_q) begin
                    if (f_mid > y_q) begin
                        lo_d = mid + DATA_W'(1);
                    end else begin
                        hi_d = mid;
                    end
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(ITER - 1)) begin
                    x_d     = lo_d;
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            lo_q    <= '0;
            hi_q    <= '0;
            y_q     <= '0;
            x_q     <= '0;
            clip_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            y_q     <= y_d;
            x_q     <= x_d;
            clip_q  <= clip_d;
            cnt_q   <= cnt_d;
        end
    end

    assign x_out = x_q;
    assign clip  = clip_q;
    assign busy  = (state_q != StIdle);

endmodule
